// File: rtl/dac_spi_pkg.sv
// Shared types and widths for the AD9783 dual-DAC SPI arbiter.
// Frame layout: {rw, 2'b00, addr[4:0], data[7:0]}, MSB first.
package dac_spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  // Reads drive zeros in the data field.
  function automatic logic [FRAME_W-1:0] make_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {rw, 2'b00, addr, rw ? {DATA_W{1'b0}} : data};
  endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// Frame shift register, SCK divider and SDI capture.
// SCK is low for the first half of each bit and high for the second.
module dac_spi_shifter
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               run,
  input  logic [FRAME_W-1:0] frame,
  input  logic               sdi,
  output logic               sck,
  output logic               sdo,
  output logic [DATA_W-1:0]  rx,
  output logic               last
);

  logic [FRAME_W-1:0] sr;
  logic [8:0]         div;
  logic [3:0]         bitc;
  logic               edge_mid;
  logic               edge_end;

  assign edge_mid = run && (div == 9'(CLK_DIV - 1));
  assign edge_end = run && (div == 9'(2 * CLK_DIV - 1));
  assign last     = edge_end && (bitc == 4'd15);
  assign sdo      = sr[FRAME_W-1];

  // Shift, divide and capture readback bits 7..0 as SCK rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      div  <= '0;
      bitc <= '0;
      sck  <= 1'b0;
      rx   <= '0;
    end else if (load) begin
      sr   <= frame;
      div  <= '0;
      bitc <= '0;
      sck  <= 1'b0;
    end else if (run) begin
      div <= edge_end ? '0 : div + 9'd1;
      if (edge_mid) sck <= 1'b1;
      if (edge_end) begin
        sck  <= 1'b0;
        sr   <= {sr[FRAME_W-2:0], 1'b0};
        bitc <= bitc + 4'd1;
      end
      if (div == 9'(CLK_DIV) && bitc >= 4'd8)
        rx <= {rx[DATA_W-2:0], sdi};
    end
  end

endmodule

// File: rtl/dac_spi_arbiter.sv
// Two-requester arbiter in front of a shared AD9783 SPI bus.
// Round-robin grant; chip select n belongs to requester n.
module dac_spi_arbiter
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              cmd0_trig_in,
  input  logic              cmd1_trig_in,
  input  logic              cmd0_rw_in,
  input  logic              cmd1_rw_in,
  input  logic [ADDR_W-1:0] cmd0_addr_in,
  input  logic [ADDR_W-1:0] cmd1_addr_in,
  input  logic [DATA_W-1:0] cmd0_data_in,
  input  logic [DATA_W-1:0] cmd1_data_in,
  output logic              cmd0_busy_out,
  output logic              cmd1_busy_out,
  output logic              cmd0_done_out,
  output logic              cmd1_done_out,
  output logic [DATA_W-1:0] cmd0_data_out,
  output logic [DATA_W-1:0] cmd1_data_out,
  output logic              spi_scs0_out,
  output logic              spi_scs1_out,
  output logic              spi_sck_out,
  output logic              spi_sdo_out,
  input  logic              spi_sdi_in
);

  state_t state, state_nxt;

  logic [7:0]                   cnt;
  logic                         cnt_end;
  logic [1:0]                   trig, rw_in, rw_q;
  logic [1:0][ADDR_W-1:0]       addr_in, addr_q;
  logic [1:0][DATA_W-1:0]       data_in, data_q, dout;
  logic [1:0]                   busy, req, done, scs;
  logic                         grant, grant_nxt, last_grant, pick;
  logic                         load, cur_rw, shift_last;
  logic                         sel_rw;
  logic [ADDR_W-1:0]            sel_addr;
  logic [DATA_W-1:0]            sel_data;
  logic [DATA_W-1:0]            rx;

  assign trig    = {cmd1_trig_in, cmd0_trig_in};
  assign rw_in   = {cmd1_rw_in, cmd0_rw_in};
  assign addr_in = {cmd1_addr_in, cmd0_addr_in};
  assign data_in = {cmd1_data_in, cmd0_data_in};
  assign cnt_end = (cnt == 8'(CLK_DIV - 1));

  // Requests and round-robin pick; the finishing requester is masked in DONE.
  always_comb begin
    req = busy | trig;
    if (state == DONE) req[grant] = 1'b0;
    pick     = (req == 2'b11) ? ~last_grant : req[1];
    sel_rw   = busy[pick] ? rw_q[pick]   : rw_in[pick];
    sel_addr = busy[pick] ? addr_q[pick] : addr_in[pick];
    sel_data = busy[pick] ? data_q[pick] : data_in[pick];
  end

  // Next-state logic; DONE chains straight into SETUP when work is waiting.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE:  if (|req) begin
               state_nxt = SETUP;
               load      = 1'b1;
             end
      SETUP: if (cnt_end) state_nxt = SHIFT;
      SHIFT: if (shift_last) state_nxt = HOLD;
      HOLD:  if (cnt_end) state_nxt = DONE;
      DONE:  begin
               state_nxt = IDLE;
               if (|req) begin
                 state_nxt = SETUP;
                 load      = 1'b1;
               end
             end
      default: state_nxt = IDLE;
    endcase
    grant_nxt = load ? pick : grant;
  end

  // State register, phase counter and grant bookkeeping.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      cnt        <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cur_rw     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 8'd1;
      if (load) begin
        grant      <= pick;
        last_grant <= pick;
        cur_rw     <= sel_rw;
      end
    end
  end

  // Accept triggers only while idle for that requester; latch the command.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy   <= '0;
      rw_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (trig[n] && !busy[n]) begin
          busy[n]   <= 1'b1;
          rw_q[n]   <= rw_in[n];
          addr_q[n] <= addr_in[n];
          data_q[n] <= data_in[n];
        end else if (state == DONE && grant == n[0]) begin
          busy[n] <= 1'b0;
        end
      end
    end
  end

  // Registered chip selects, done pulses and readback data.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      scs  <= 2'b11;
      done <= '0;
      dout <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        scs[n]  <= !(grant_nxt == n[0] &&
                     (state_nxt == SETUP || state_nxt == SHIFT ||
                      state_nxt == HOLD));
        done[n] <= (state_nxt == DONE) && (grant == n[0]);
        if (state_nxt == DONE && grant == n[0] && cur_rw)
          dout[n] <= rx;
      end
    end
  end

  dac_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .load  (load),
    .run   (state == SHIFT),
    .frame (make_frame(sel_rw, sel_addr, sel_data)),
    .sdi   (spi_sdi_in),
    .sck   (spi_sck_out),
    .sdo   (spi_sdo_out),
    .rx    (rx),
    .last  (shift_last)
  );

  assign cmd0_busy_out = busy[0];
  assign cmd1_busy_out = busy[1];
  assign cmd0_done_out = done[0];
  assign cmd1_done_out = done[1];
  assign cmd0_data_out = dout[0];
  assign cmd1_data_out = dout[1];
  assign spi_scs0_out  = scs[0];
  assign spi_scs1_out  = scs[1];

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Directed bench for dac_spi_arbiter with a completion-order scoreboard.
// Instance A runs CLK_DIV=4, instance B runs CLK_DIV=2 for the stream.
module tb_dac_spi_arbiter;

  localparam int D  = 4;
  localparam int DB = 2;

  typedef struct {
    int          r;
    logic [15:0] frame;
    bit          rd;
    logic [7:0]  rb;
    int          tt;
    bit          lat;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n;
  logic [1:0] trig, rw;
  logic [4:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       busy0, busy1, done0, done1;
  logic [7:0] dout0, dout1;
  logic       scs0, scs1, sck, sdo;
  logic       sdi = 1'b0;

  logic [1:0] trig_b;
  logic       busyb0, busyb1, doneb0, doneb1;
  logic [7:0] doutb0, doutb1;
  logic       scsb0, scsb1, sckb, sdob;
  logic       sdi_b = 1'b0;

  dac_spi_arbiter #(.CLK_DIV(D)) u_dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .cmd0_trig_in  (trig[0]),
    .cmd1_trig_in  (trig[1]),
    .cmd0_rw_in    (rw[0]),
    .cmd1_rw_in    (rw[1]),
    .cmd0_addr_in  (addr0),
    .cmd1_addr_in  (addr1),
    .cmd0_data_in  (data0),
    .cmd1_data_in  (data1),
    .cmd0_busy_out (busy0),
    .cmd1_busy_out (busy1),
    .cmd0_done_out (done0),
    .cmd1_done_out (done1),
    .cmd0_data_out (dout0),
    .cmd1_data_out (dout1),
    .spi_scs0_out  (scs0),
    .spi_scs1_out  (scs1),
    .spi_sck_out   (sck),
    .spi_sdo_out   (sdo),
    .spi_sdi_in    (sdi)
  );

  dac_spi_arbiter #(.CLK_DIV(DB)) u_dut_b (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .cmd0_trig_in  (trig_b[0]),
    .cmd1_trig_in  (trig_b[1]),
    .cmd0_rw_in    (1'b0),
    .cmd1_rw_in    (1'b0),
    .cmd0_addr_in  (5'h0A),
    .cmd1_addr_in  (5'h15),
    .cmd0_data_in  (8'h5A),
    .cmd1_data_in  (8'hC3),
    .cmd0_busy_out (busyb0),
    .cmd1_busy_out (busyb1),
    .cmd0_done_out (doneb0),
    .cmd1_done_out (doneb1),
    .cmd0_data_out (doutb0),
    .cmd1_data_out (doutb1),
    .spi_scs0_out  (scsb0),
    .spi_scs1_out  (scsb1),
    .spi_sck_out   (sckb),
    .spi_sdo_out   (sdob),
    .spi_sdi_in    (sdi_b)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fr(input bit r, input logic [4:0] a,
                                     input logic [7:0] d);
    return {r, 2'b00, a, r ? 8'h00 : d};
  endfunction

  item_t       q[$];
  logic [7:0]  exp_dout[2];
  int          t_trig;
  logic [15:0] mframe;
  int          nbits, nfalls, lowcnt, tstart;
  logic        sck_p = 1'b0, scs0_p = 1'b1, scs1_p = 1'b1;
  int          done_t[2];
  int          done_n[2];
  bit          overlap = 1'b0;

  // Bus monitor, SDI model and scoreboard for instance A.
  always @(negedge clk) begin
    item_t it;
    if (!scs0 && !scs1) overlap = 1'b1;
    if ((scs0_p && !scs0) || (scs1_p && !scs1)) begin
      nbits  = 0;
      nfalls = 0;
      mframe = '0;
      lowcnt = 0;
      tstart = cyc;
    end
    if (!scs0 || !scs1) lowcnt++;
    if (sck && !sck_p) begin
      mframe = {mframe[14:0], sdo};
      nbits++;
    end
    if (!sck && sck_p) nfalls++;
    sdi = (q.size() > 0 && q[0].rd && nfalls >= 8 && nfalls <= 15) ?
          q[0].rb[15-nfalls] : 1'b0;
    if (done0 || done1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", {30'd0, done1, done0}, 32'd0);
      end else begin
        it = q.pop_front();
        chk("done_req", {30'd0, done1, done0}, it.r ? 32'd2 : 32'd1);
        chk("frame", {16'd0, mframe}, {16'd0, it.frame});
        chk("nbits", nbits, 16);
        if (it.rd) exp_dout[it.r] = it.rb;
        chk("dout0", {24'd0, dout0}, {24'd0, exp_dout[0]});
        chk("dout1", {24'd0, dout1}, {24'd0, exp_dout[1]});
        chk("scs_done_high", {30'd0, scs1, scs0}, 32'd3);
        if (it.lat) begin
          chk("scs_start", tstart, it.tt + 1);
          chk("scs_low_len", lowcnt, 34 * D);
          chk("done_lat", cyc, it.tt + 34 * D + 1);
        end
        done_t[it.r] = cyc;
        done_n[it.r]++;
      end
    end
    sck_p  = sck;
    scs0_p = scs0;
    scs1_p = scs1;
  end

  int bdone_n = 0;
  int bdone_t = 0;
  bit b_overlap = 1'b0;

  // Spacing and order monitor for instance B.
  always @(negedge clk) begin
    if (!scsb0 && !scsb1) b_overlap = 1'b1;
    if (doneb0 || doneb1) begin
      chk("b_req", {30'd0, doneb1, doneb0},
          (bdone_n % 2) ? 32'd2 : 32'd1);
      if (bdone_n > 0) chk("b_gap", cyc - bdone_t, 69);
      bdone_t = cyc;
      bdone_n++;
    end
  end

  task automatic fire(input logic [1:0] m);
    @(posedge clk);
    #1;
    trig   = m;
    t_trig = cyc;
  endtask

  task automatic release_trig();
    @(posedge clk);
    #1;
    trig = 2'b00;
  endtask

  task automatic push(input int r, input logic [15:0] f, input bit rd,
                      input logic [7:0] rb, input bit lat);
    item_t it;
    it.r     = r;
    it.frame = f;
    it.rd    = rd;
    it.rb    = rb;
    it.tt    = t_trig;
    it.lat   = lat;
    q.push_back(it);
  endtask

  task automatic wait_empty(input int lim, output logic [1:0] scs_and);
    int n = 0;
    scs_and = 2'b11;
    while (q.size() > 0 && n < lim) begin
      @(negedge clk);
      scs_and = scs_and & {scs1, scs0};
      n++;
    end
    chk("timeout", q.size(), 0);
  endtask

  initial begin
    logic [1:0] sa;
    int         issued;
    int         n;
    int         d0;
    rst_n       = 1'b0;
    trig        = '0;
    rw          = '0;
    addr0       = '0;
    addr1       = '0;
    data0       = '0;
    data1       = '0;
    trig_b      = '0;
    exp_dout[0] = '0;
    exp_dout[1] = '0;
    done_n[0]   = 0;
    done_n[1]   = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_scs", {30'd0, scs1, scs0}, 32'd3);
    chk("rst_sck_sdo", {30'd0, sck, sdo}, 32'd0);
    chk("rst_busy", {30'd0, busy1, busy0}, 32'd0);
    chk("rst_done", {30'd0, done1, done0}, 32'd0);
    chk("rst_dout", {16'd0, dout1, dout0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous pair right after reset: requester 0 first.
    rw    = 2'b00;
    addr0 = 5'h01;
    data0 = 8'h11;
    addr1 = 5'h03;
    data1 = 8'h33;
    fire(2'b11);
    push(0, fr(1'b0, 5'h01, 8'h11), 1'b0, 8'h00, 1'b1);
    push(1, fr(1'b0, 5'h03, 8'h33), 1'b0, 8'h00, 1'b0);
    release_trig();
    chk("pair_busy", {30'd0, busy1, busy0}, 32'd3);
    wait_empty(1000, sa);
    chk("pair_gap", done_t[1] - done_t[0], 34 * D + 1);

    // Second pair: last grant was 1, so 0 wins again.
    addr0 = 5'h07;
    data0 = 8'hE1;
    addr1 = 5'h08;
    data1 = 8'h1E;
    fire(2'b11);
    push(0, fr(1'b0, 5'h07, 8'hE1), 1'b0, 8'h00, 1'b1);
    push(1, fr(1'b0, 5'h08, 8'h1E), 1'b0, 8'h00, 1'b0);
    release_trig();
    wait_empty(1000, sa);
    chk("pair2_gap", done_t[1] - done_t[0], 34 * D + 1);

    // Single write with exact latency.
    addr0 = 5'h02;
    data0 = 8'hA5;
    fire(2'b01);
    push(0, 16'h02A5, 1'b0, 8'h00, 1'b1);
    release_trig();
    chk("wr_busy", {31'd0, busy0}, 32'd1);
    wait_empty(400, sa);
    chk("wr_scs1_high", {31'd0, sa[1]}, 32'd1);
    @(posedge clk);
    #1;
    chk("wr_busy_clr", {31'd0, busy0}, 32'd0);

    // Read from requester 1; data field must go out as zeros.
    rw    = 2'b10;
    addr1 = 5'h1F;
    data1 = 8'h77;
    fire(2'b10);
    push(1, 16'h9F00, 1'b1, 8'h3C, 1'b1);
    release_trig();
    wait_empty(400, sa);
    chk("rd_scs0_high", {31'd0, sa[0]}, 32'd1);
    chk("rd_dout1", {24'd0, dout1}, 32'h3C);
    chk("rd_dout0", {24'd0, dout0}, 32'h00);
    rw = 2'b00;

    // Retrigger while busy and in the DONE cycle: both ignored.
    d0    = done_n[0];
    addr0 = 5'h04;
    data0 = 8'h5A;
    fire(2'b01);
    push(0, fr(1'b0, 5'h04, 8'h5A), 1'b0, 8'h00, 1'b1);
    release_trig();
    repeat (40) @(posedge clk);
    #1;
    data0 = 8'hFF;
    trig  = 2'b01;
    release_trig();
    n = 0;
    while (cyc < t_trig + 34 * D + 1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rt_done_cycle", {31'd0, done0}, 32'd1);
    chk("rt_busy_in_done", {31'd0, busy0}, 32'd1);
    trig = 2'b01;
    release_trig();
    wait_empty(50, sa);
    repeat (200) @(negedge clk);
    chk("rt_one_done", done_n[0] - d0, 1);
    chk("rt_busy_clr", {31'd0, busy0}, 32'd0);

    // Reset in bit 8 of SHIFT, with SCK high.
    addr0 = 5'h06;
    data0 = 8'hC3;
    fire(2'b01);
    push(0, fr(1'b0, 5'h06, 8'hC3), 1'b0, 8'h00, 1'b0);
    release_trig();
    n = 0;
    while (cyc < t_trig + 74 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_sck_high", {31'd0, sck}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scs", {30'd0, scs1, scs0}, 32'd3);
    chk("mid_rst_sck_sdo", {30'd0, sck, sdo}, 32'd0);
    chk("mid_rst_busy", {30'd0, busy1, busy0}, 32'd0);
    chk("mid_rst_dout", {16'd0, dout1, dout0}, 32'd0);
    q.delete();
    exp_dout[0] = '0;
    exp_dout[1] = '0;
    d0 = done_n[0] + done_n[1];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("mid_no_done", done_n[0] + done_n[1] - d0, 0);
    addr1 = 5'h11;
    data1 = 8'h96;
    fire(2'b10);
    push(1, fr(1'b0, 5'h11, 8'h96), 1'b0, 8'h00, 1'b1);
    release_trig();
    wait_empty(400, sa);

    // Back-to-back alternating stream on the CLK_DIV=2 instance.
    issued = 0;
    n      = 0;
    while (bdone_n < 10 && n < 2000) begin
      @(posedge clk);
      #1;
      trig_b = 2'b00;
      if (!busyb0 && issued < 10) begin
        trig_b[0] = 1'b1;
        issued++;
      end
      if (!busyb1 && issued < 10) begin
        trig_b[1] = 1'b1;
        issued++;
      end
      n++;
    end
    trig_b = 2'b00;
    chk("b_count", bdone_n, 10);
    chk("b_overlap", {31'd0, b_overlap}, 32'd0);
    chk("a_overlap", {31'd0, overlap}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/dac_spi_arbiter.md
DAC_SPI_ARBITER -- requirements
Module: dac_spi_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in clk_in cycles; legal range 2..255.
REQ-002 SHALL have port clk_in, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n_in, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports cmd0_trig_in and cmd1_trig_in, input, 1 each: one-cycle request strobe from requester 0 or 1.
REQ-005 SHALL have ports cmd0_rw_in and cmd1_rw_in, input, 1 each: 1 = read, 0 = write.
REQ-006 SHALL have ports cmd0_addr_in and cmd1_addr_in, input, 5 each: AD9783 register address.
REQ-007 SHALL have ports cmd0_data_in and cmd1_data_in, input, 8 each: write data.
REQ-008 SHALL have ports cmd0_busy_out and cmd1_busy_out, output, 1 each: request pending or in flight.
REQ-009 SHALL have ports cmd0_done_out and cmd1_done_out, output, 1 each: one-cycle completion pulse.
REQ-010 SHALL have ports cmd0_data_out and cmd1_data_out, output, 8 each: last read data for that requester.
REQ-011 SHALL have ports spi_scs0_out and spi_scs1_out, output, 1 each: active-low chip select for DAC chip 0 or 1.
REQ-012 SHALL have port spi_sck_out, output, 1: shared SPI clock.
REQ-013 SHALL have port spi_sdo_out, output, 1: shared serial data to both DACs.
REQ-014 SHALL have port spi_sdi_in, input, 1: shared serial readback.

Function
REQ-015 SHALL map requester n exclusively to spi_scsn_out.
REQ-016 SHALL accept a trig only while that requester's busy is low; it latches rw, addr and data, sets busy the next cycle, and ignores trigs while busy is high.
REQ-017 SHALL use FSM states IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-018 SHALL, in IDLE, grant a pending or same-cycle-triggered requester and enter SETUP next cycle; when both qualify, grant the one not granted last (last_grant resets to 1, so requester 0 wins first).
REQ-019 SHALL hold SETUP for CLK_DIV cycles with the granted scs low, sck low and sdo = frame bit 15.
REQ-020 SHALL use frame {rw, 2'b00, addr[4:0], data[7:0]}, sent MSB first, with sdo driven 0 in data bits when rw=1.
REQ-021 SHALL run SHIFT for 16 bits of 2*CLK_DIV cycles each, with sck low for the first half and high for the second half, and change sdo only at the sck falling edge.
REQ-022 SHALL, for reads, sample spi_sdi_in on the clk_in cycle sck rises during frame bits 7..0, MSB first.
REQ-023 SHALL hold HOLD for CLK_DIV cycles with scs low and sck low, then enter DONE.
REQ-024 SHALL, in DONE, last 1 cycle with both scs high, pulse the granted done, load cmdn_data_out on reads only, clear busy on the next cycle and return to IDLE.
REQ-025 SHALL give latency, with trig in cycle 0 on an idle block, of scs low in cycles 1..34*CLK_DIV and done in cycle 34*CLK_DIV+1.
REQ-026 SHALL ignore a trig in the DONE cycle of its own transaction, because busy is still high.
REQ-027 SHALL hold the other requester's pending request through an active transaction and grant it from IDLE with no extra gap beyond DONE.
REQ-028 SHALL never assert both scs low in the same cycle.

Reset
REQ-029 SHALL, while rst_n_in is low, including mid-transaction, force IDLE, both scs high, sck 0, sdo 0, busy 0, done 0, data_out 8'h00, pending cleared and last_grant=1; no done pulse SHALL follow.
REQ-030 SHALL deassert reset without a glitch on scs or sck.

Structure
REQ-031 SHALL place the FSM state enum, frame width (16), address width (5) and data width (8) in shared package dac_spi_pkg.
REQ-032 SHALL contain one sub-module, dac_spi_shifter, that holds the frame shift register, sck divider and sdi capture; arbitration and the FSM stay in the top level.

Verification
REQ-033 SHALL test: CLK_DIV=4, cmd0 write addr 5'h02 data 8'hA5 -> scs0 low cycles 1..136, sdo bits 0x02A5 valid at 16 sck rises, done0 at cycle 137, scs1 high throughout.
REQ-034 SHALL test: cmd1 read addr 5'h1F, sdi model returns 8'h3C -> frame 0x9F00 on sdo, cmd1_data_out=8'h3C at done1, cmd0_data_out unchanged.
REQ-035 SHALL test: both trigs in the same cycle after reset -> requester 0 served first, requester 1 granted immediately after DONE; a further simultaneous pair -> requester 0 first again, since last_grant=1.
REQ-036 SHALL test: cmd0 retriggered mid-transaction and in its DONE cycle -> ignored; exactly one done0 pulse.
REQ-037 SHALL test: rst_n_in low at bit 8 of SHIFT -> both scs high, sck 0 within the same cycle, no done, busy 0; a new trig afterwards completes normally.
REQ-038 SHALL test: CLK_DIV=2 with a back-to-back stream of 10 alternating requests -> no scs overlap, each done spaced exactly 69 cycles apart.
